// File: rtl/axi_wr_addr_buffer.sv
// AXI3 write-address channel buffer: DEPTH-entry FIFO between an AW master and slave,
// with downstream issue throttled to MAX_OUTSTANDING writes awaiting their B response.
module axi_wr_addr_buffer #(
    parameter int ID_MAX_WIDTH    = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int PTR_W          = $clog2(DEPTH),
    localparam int OST_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s_awvalid,
    output logic                    s_awready,
    input  logic [ID_MAX_WIDTH-1:0] s_awid,
    input  logic [ADDR_WIDTH-1:0]   s_awaddr,
    input  logic [3:0]              s_awlen,
    input  logic [2:0]              s_awsize,
    input  logic [1:0]              s_awbrust,
    input  logic [1:0]              s_awlock,
    input  logic [3:0]              s_awcache,
    input  logic [2:0]              s_awprot,
    input  logic [3:0]              s_awqos,

    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ID_MAX_WIDTH-1:0] m_awid,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic [3:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awbrust,
    output logic [1:0]              m_awlock,
    output logic [3:0]              m_awcache,
    output logic [2:0]              m_awprot,
    output logic [3:0]              m_awqos,

    input  logic                    bvalid,
    input  logic                    bready,

    output logic [PTR_W:0]          fifo_count,
    output logic [OST_W-1:0]        ost_count,
    output logic                    b_underflow
);

    typedef struct packed {
        logic [ID_MAX_WIDTH-1:0] id;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [3:0]              len;
        logic [2:0]              size;
        logic [1:0]              brust;
        logic [1:0]              lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
        logic [3:0]              qos;
    } aw_t;

    localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [OST_W-1:0] OST_LIM  = OST_W'(MAX_OUTSTANDING);

    aw_t              mem [DEPTH];
    aw_t              wr_ent;
    aw_t              head;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [PTR_W:0]   cnt;
    logic [OST_W-1:0] ost;
    logic             uf;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             bfire;
    logic             b_ret;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_FULL);

    // Ready depends only on the registered count, never on m_awready, so a full
    // FIFO refuses a push even while it is popping that same cycle.
    assign s_awready = !rst && !full;
    assign m_awvalid = !empty && (ost < OST_LIM);

    assign push  = s_awvalid && s_awready;
    assign pop   = m_awvalid && m_awready;
    assign bfire = bvalid && bready;
    assign b_ret = bfire && (ost != '0);

    assign wr_ent = '{id: s_awid, addr: s_awaddr, len: s_awlen, size: s_awsize,
                      brust: s_awbrust, lock: s_awlock, cache: s_awcache,
                      prot: s_awprot, qos: s_awqos};

    // Head is zeroed while empty so stale entries never show on the bus.
    assign head = empty ? '0 : mem[rptr];

    assign m_awid    = head.id;
    assign m_awaddr  = head.addr;
    assign m_awlen   = head.len;
    assign m_awsize  = head.size;
    assign m_awbrust = head.brust;
    assign m_awlock  = head.lock;
    assign m_awcache = head.cache;
    assign m_awprot  = head.prot;
    assign m_awqos   = head.qos;

    assign fifo_count  = cnt;
    assign ost_count   = ost;
    assign b_underflow = uf;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wr_ent;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
            ost  <= '0;
            uf   <= 1'b0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;

            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase

            // A B response with nothing in flight is flagged, not counted.
            case ({pop, b_ret})
                2'b10:   ost <= ost + 1'b1;
                2'b01:   ost <= ost - 1'b1;
                default: ost <= ost;
            endcase

            if (bfire && (ost == '0)) uf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_wr_addr_buffer.sv
// Bench for axi_wr_addr_buffer: directed vector table for reset/latency/full/throttle/
// underflow cases, then a randomized run of 10k AWs against a queue scoreboard.
module tb_axi_wr_addr_buffer;

    localparam int DEPTH   = 4;
    localparam int MAX_OST = 2;
    localparam int N_RAND  = 10000;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  brust;
        logic [1:0]  lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
        logic [3:0]  qos;
    } aw_t;

    typedef struct {
        logic        rst, sv;
        logic [3:0]  id;
        logic [31:0] addr;
        logic        mr, bv, br;
        logic        sr, mv;
        logic [2:0]  fc;
        logic [1:0]  ost;
        logic        uf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_awvalid, s_awready;
    logic [3:0]  s_awid;
    logic [31:0] s_awaddr;
    logic [3:0]  s_awlen;
    logic [2:0]  s_awsize;
    logic [1:0]  s_awbrust, s_awlock;
    logic [3:0]  s_awcache;
    logic [2:0]  s_awprot;
    logic [3:0]  s_awqos;
    logic        m_awvalid, m_awready;
    logic [3:0]  m_awid;
    logic [31:0] m_awaddr;
    logic [3:0]  m_awlen;
    logic [2:0]  m_awsize;
    logic [1:0]  m_awbrust, m_awlock;
    logic [3:0]  m_awcache;
    logic [2:0]  m_awprot;
    logic [3:0]  m_awqos;
    logic        bvalid, bready;
    logic [2:0]  fifo_count;
    logic [1:0]  ost_count;
    logic        b_underflow;

    axi_wr_addr_buffer #(
        .ID_MAX_WIDTH(4), .ADDR_WIDTH(32), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OST)
    ) dut (
        .clk(clk), .rst(rst),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid), .s_awaddr(s_awaddr),
        .s_awlen(s_awlen), .s_awsize(s_awsize), .s_awbrust(s_awbrust), .s_awlock(s_awlock),
        .s_awcache(s_awcache), .s_awprot(s_awprot), .s_awqos(s_awqos),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid), .m_awaddr(m_awaddr),
        .m_awlen(m_awlen), .m_awsize(m_awsize), .m_awbrust(m_awbrust), .m_awlock(m_awlock),
        .m_awcache(m_awcache), .m_awprot(m_awprot), .m_awqos(m_awqos),
        .bvalid(bvalid), .bready(bready),
        .fifo_count(fifo_count), .ost_count(ost_count), .b_underflow(b_underflow)
    );

    always #5 clk = ~clk;

    int    n_chk  = 0;
    int    n_pass = 0;
    int    n_push = 0;
    int    n_pop  = 0;
    string tag    = "init";

    // Scoreboard: accepted AWs in order, plus expected in-flight count and sticky flag.
    aw_t   mq [$];
    int    m_ost = 0;
    logic  m_uf  = 1'b0;

    vec_t  tbl [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s [%s]: got 0x%0h, expected 0x%0h", nm, tag, act, exp);
    endtask

    function automatic aw_t mk(input logic [3:0] id, input logic [31:0] addr);
        aw_t f;
        f.id    = id;
        f.addr  = addr;
        f.len   = addr[15:12] ^ id;
        f.size  = id[2:0];
        f.brust = id[1:0];
        f.lock  = ~id[1:0];
        f.cache = ~id;
        f.prot  = addr[14:12];
        f.qos   = id + 4'd1;
        return f;
    endfunction

    function automatic aw_t rnd_aw();
        aw_t f;
        f.id    = 4'($urandom);
        f.addr  = $urandom;
        f.len   = 4'($urandom);
        f.size  = 3'($urandom);
        f.brust = 2'($urandom);
        f.lock  = 2'($urandom);
        f.cache = 4'($urandom);
        f.prot  = 3'($urandom);
        f.qos   = 4'($urandom);
        return f;
    endfunction

    function automatic vec_t V(input int r, input int sv, input int id, input logic [31:0] addr,
                               input int mr, input int bv, input int br, input int sr,
                               input int mv, input int fc, input int ost, input int uf);
        vec_t v;
        v.rst = 1'(r);  v.sv = 1'(sv);  v.id = 4'(id);  v.addr = addr;
        v.mr  = 1'(mr); v.bv = 1'(bv);  v.br = 1'(br);
        v.sr  = 1'(sr); v.mv = 1'(mv);  v.fc = 3'(fc);  v.ost = 2'(ost); v.uf = 1'(uf);
        return v;
    endfunction

    // One clock: drive at posedge+1, check model at negedge, advance model, return at posedge+1.
    task automatic cycle(input logic r, input logic sv, input aw_t f, input logic mr,
                         input logic bv, input logic br,
                         output logic o_sr, output logic o_mv, output logic [2:0] o_fc,
                         output logic [1:0] o_ost, output logic o_uf);
        logic e_sr, e_mv, push_e, pop_e;
        aw_t  e_head, d_head;
        rst = r; s_awvalid = sv; m_awready = mr; bvalid = bv; bready = br;
        {s_awid, s_awaddr, s_awlen, s_awsize, s_awbrust, s_awlock, s_awcache, s_awprot, s_awqos} = f;
        @(negedge clk);
        o_sr = s_awready; o_mv = m_awvalid; o_fc = fifo_count; o_ost = ost_count; o_uf = b_underflow;
        e_sr   = !r && (mq.size() < DEPTH);
        e_mv   = (mq.size() != 0) && (m_ost < MAX_OST);
        e_head = (mq.size() != 0) ? mq[0] : '0;
        d_head = {m_awid, m_awaddr, m_awlen, m_awsize, m_awbrust, m_awlock, m_awcache, m_awprot, m_awqos};
        chk("sb_s_awready", 64'(s_awready), 64'(e_sr));
        chk("sb_m_awvalid", 64'(m_awvalid), 64'(e_mv));
        chk("sb_m_aw_fields", 64'(d_head), 64'(e_head));
        chk("sb_fifo_count", 64'(fifo_count), 64'(mq.size()));
        chk("sb_ost_count", 64'(ost_count), 64'(m_ost));
        chk("sb_b_underflow", 64'(b_underflow), 64'(m_uf));
        if (r) begin
            mq.delete();
            m_ost = 0;
            m_uf  = 1'b0;
        end else begin
            pop_e  = e_mv && mr;
            push_e = sv && e_sr;
            if (pop_e) begin
                void'(mq.pop_front());
                n_pop++;
            end
            if (push_e) begin
                mq.push_back(f);
                n_push++;
            end
            if (bv && br) begin
                if (m_ost == 0) m_uf = 1'b1;
                else m_ost--;
            end
            if (pop_e) m_ost++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic       o_sr, o_mv, o_uf;
        logic [2:0] o_fc;
        logic [1:0] o_ost;
        logic       bv;
        int         cyc;

        rst = 1'b1; s_awvalid = 1'b0; m_awready = 1'b0; bvalid = 1'b0; bready = 1'b0;
        {s_awid, s_awaddr, s_awlen, s_awsize, s_awbrust, s_awlock, s_awcache, s_awprot, s_awqos} = '0;
        @(posedge clk);
        #1;

        //                rst sv id addr      mr bv br | sr mv fc ost uf
        // reset held with s_awvalid asserted
        tbl.push_back(V(1, 1, 7, 32'hDEAD, 0, 0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(V(1, 1, 7, 32'hDEAD, 0, 0, 0,   0, 0, 0, 0, 0));
        tbl.push_back(V(1, 1, 7, 32'hDEAD, 0, 0, 0,   0, 0, 0, 0, 0));
        // latency/order: back-to-back pushes, second B-less issue throttles the third
        tbl.push_back(V(0, 1, 1, 32'h1000, 1, 0, 0,   1, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 2, 32'h2000, 1, 0, 0,   1, 1, 1, 0, 0));
        tbl.push_back(V(0, 1, 3, 32'h3000, 1, 0, 0,   1, 1, 1, 1, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 0,   1, 0, 1, 2, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 1,   1, 0, 1, 2, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 1,   1, 1, 1, 1, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 1,   1, 0, 0, 1, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 0, 0,   1, 0, 0, 0, 0));
        // full: 4 accepted, 5th held until one pop frees a slot
        tbl.push_back(V(0, 1, 4, 32'h4000, 0, 0, 0,   1, 0, 0, 0, 0));
        tbl.push_back(V(0, 1, 5, 32'h5000, 0, 0, 0,   1, 1, 1, 0, 0));
        tbl.push_back(V(0, 1, 6, 32'h6000, 0, 0, 0,   1, 1, 2, 0, 0));
        tbl.push_back(V(0, 1, 7, 32'h7000, 0, 0, 0,   1, 1, 3, 0, 0));
        tbl.push_back(V(0, 1, 8, 32'h8000, 0, 0, 0,   0, 1, 4, 0, 0));
        tbl.push_back(V(0, 1, 8, 32'h8000, 1, 0, 0,   0, 1, 4, 0, 0));
        tbl.push_back(V(0, 1, 8, 32'h8000, 0, 0, 0,   1, 1, 3, 1, 0));
        // throttle at 2 in flight; one B releases exactly one issue
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 0,   0, 1, 4, 1, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 0,   1, 0, 3, 2, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 0,   1, 0, 3, 2, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 1,   1, 0, 3, 2, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 0,   1, 1, 3, 1, 0));
        // push and pop together at fifo_count 2
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 1, 1,   1, 0, 2, 2, 0));
        tbl.push_back(V(0, 1, 9, 32'h9000, 1, 0, 0,   1, 1, 2, 1, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 0, 0,   1, 0, 2, 2, 0));
        // drain with pop + B together
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 1,   1, 0, 2, 2, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 1,   1, 1, 2, 1, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 1,   1, 1, 1, 1, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 1, 1,   1, 0, 0, 1, 0));
        // underflow: B with nothing in flight, sticky across later traffic
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 1, 1,   1, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    0, 0, 0,   1, 0, 0, 0, 1));
        tbl.push_back(V(0, 1, 10, 32'hA000, 1, 0, 0,  1, 0, 0, 0, 1));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 0,   1, 1, 1, 0, 1));
        tbl.push_back(V(0, 1, 11, 32'hB000, 0, 1, 1,  1, 0, 0, 1, 1));
        // reset with an entry held: discarded, flag cleared, nothing replayed
        tbl.push_back(V(1, 0, 0, 32'h0,    0, 0, 0,   0, 1, 1, 0, 1));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 0,   1, 0, 0, 0, 0));
        tbl.push_back(V(0, 0, 0, 32'h0,    1, 0, 0,   1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            tag = $sformatf("vec%0d", i);
            cycle(tbl[i].rst, tbl[i].sv, mk(tbl[i].id, tbl[i].addr), tbl[i].mr, tbl[i].bv,
                  tbl[i].br, o_sr, o_mv, o_fc, o_ost, o_uf);
            chk("vec_s_awready", 64'(o_sr), 64'(tbl[i].sr));
            chk("vec_m_awvalid", 64'(o_mv), 64'(tbl[i].mv));
            chk("vec_fifo_count", 64'(o_fc), 64'(tbl[i].fc));
            chk("vec_ost_count", 64'(o_ost), 64'(tbl[i].ost));
            chk("vec_b_underflow", 64'(o_uf), 64'(tbl[i].uf));
        end

        // Random valid/ready traffic; B only returned while something is in flight.
        tag = "rand";
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, o_sr, o_mv, o_fc, o_ost, o_uf);
        n_push = 0;
        n_pop  = 0;
        cyc    = 0;
        while ((n_push < N_RAND || mq.size() != 0 || m_ost != 0) && cyc < 80000) begin
            bv = (m_ost > 0) && ($urandom_range(0, 9) < 7);
            cycle(1'b0, (n_push < N_RAND) && ($urandom_range(0, 9) < 7), rnd_aw(),
                  $urandom_range(0, 9) < 7, bv, $urandom_range(0, 9) < 8,
                  o_sr, o_mv, o_fc, o_ost, o_uf);
            cyc++;
        end
        chk("rand_within_budget", 64'(cyc < 80000), 64'(1));
        chk("rand_pushed", 64'(n_push), 64'(N_RAND));
        chk("rand_popped", 64'(n_pop), 64'(N_RAND));
        chk("rand_final_uf", 64'(b_underflow), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
